// File: rtl/gb_ppu_timing.sv
// DMG PPU dot/line timing generator: scanline position, PPU mode, LYC compare
// and the STAT / VBlank interrupt pulses, one dot per clk.
module gb_ppu_timing #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned OAM_SCAN_DOTS = 80,
    parameter int unsigned DRAW_END_MAX  = 369,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic       draw_done,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_irq_en,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] ppu_mode,
    output logic       lyc_eq,
    output logic       line_start,
    output logic       stat_irq,
    output logic       vblank_irq
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_DRAW   = 2'd3
    } mode_e;

    localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_OAM   = 9'(OAM_SCAN_DOTS);
    localparam logic [8:0] DOT_DRAWN = 9'(DRAW_END_MAX);
    localparam logic [7:0] LY_VIS    = 8'(VISIBLE_LINES);
    localparam logic [7:0] LY_VBL    = 8'(VISIBLE_LINES - 1);
    localparam logic [7:0] LY_LAST   = 8'(TOTAL_LINES - 1);

    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d;
    mode_e      mode_q, mode_d;
    logic       lcd_en_q;
    logic       stat_line_q, stat_line_d;
    logic       line_start_q, line_start_d;
    logic       stat_irq_q, stat_irq_d;
    logic       vblank_irq_q, vblank_irq_d;
    logic       running_s;
    logic       lyc_eq_next_s;

    // Counting only continues once the enable has been seen for a full cycle;
    // the enable edge itself restarts the frame at line 0, dot 0.
    assign running_s = lcd_enable & lcd_en_q;

    // Dot and line counters.
    always_comb begin
        dot_d = 9'd0;
        ly_d  = 8'd0;
        if (!running_s) begin
            dot_d = 9'd0;
            ly_d  = 8'd0;
        end else if (dot_q == DOT_LAST) begin
            dot_d = 9'd0;
            if (ly_q == LY_LAST) begin
                ly_d = 8'd0;
            end else begin
                ly_d = ly_q + 8'd1;
            end
        end else begin
            dot_d = dot_q + 9'd1;
            ly_d  = ly_q;
        end
    end

    // Mode FSM next state, decided from the next-state dot/line position.
    always_comb begin
        mode_d = MODE_HBLANK;
        if (!lcd_enable) begin
            mode_d = MODE_HBLANK;
        end else if (ly_d >= LY_VIS) begin
            mode_d = MODE_VBLANK;
        end else if (dot_d < DOT_OAM) begin
            mode_d = MODE_OAM;
        end else if (dot_d == DOT_OAM) begin
            mode_d = MODE_DRAW;
        end else begin
            case (mode_q)
                MODE_DRAW: begin
                    if (draw_done || (dot_d == DOT_DRAWN)) begin
                        mode_d = MODE_HBLANK;
                    end else begin
                        mode_d = MODE_DRAW;
                    end
                end
                MODE_HBLANK: mode_d = MODE_HBLANK;
                default:     mode_d = MODE_HBLANK;
            endcase
        end
    end

    // STAT line and pulse generation; only 0->1 transitions of the line fire.
    always_comb begin
        lyc_eq_next_s = (ly_d == lyc);
        stat_line_d   = 1'b0;
        if (lcd_enable) begin
            stat_line_d = (stat_irq_en[3] & lyc_eq_next_s)
                        | (stat_irq_en[2] & (mode_d == MODE_OAM))
                        | (stat_irq_en[1] & (mode_d == MODE_VBLANK))
                        | (stat_irq_en[0] & (mode_d == MODE_HBLANK));
        end else begin
            stat_line_d = 1'b0;
        end
        stat_irq_d   = stat_line_d & ~stat_line_q;
        vblank_irq_d = running_s & (dot_q == DOT_LAST) & (ly_q == LY_VBL);
        line_start_d = lcd_enable & (dot_d == 9'd0);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dot_q        <= 9'd0;
            ly_q         <= 8'd0;
            mode_q       <= MODE_HBLANK;
            lcd_en_q     <= 1'b0;
            stat_line_q  <= 1'b0;
            line_start_q <= 1'b0;
            stat_irq_q   <= 1'b0;
            vblank_irq_q <= 1'b0;
        end else begin
            dot_q        <= dot_d;
            ly_q         <= ly_d;
            mode_q       <= mode_d;
            lcd_en_q     <= lcd_enable;
            stat_line_q  <= stat_line_d;
            line_start_q <= line_start_d;
            stat_irq_q   <= stat_irq_d;
            vblank_irq_q <= vblank_irq_d;
        end
    end

    assign ly         = ly_q;
    assign dot        = dot_q;
    assign ppu_mode   = mode_q;
    assign lyc_eq     = (ly_q == lyc);
    assign line_start = line_start_q;
    assign stat_irq   = stat_irq_q;
    assign vblank_irq = vblank_irq_q;

endmodule

// File: tb/tb_gb_ppu_timing.sv
// Directed self-checking bench for gb_ppu_timing: line sweep, draw_done,
// LYC interrupt, LCD disable/re-enable, one full frame and mid-line reset.
module tb_gb_ppu_timing;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_enable;
    logic       draw_done;
    logic [7:0] lyc;
    logic [3:0] stat_irq_en;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] ppu_mode;
    logic       lyc_eq;
    logic       line_start;
    logic       stat_irq;
    logic       vblank_irq;

    int n_checks = 0;
    int n_pass   = 0;
    int errs, cnt, hi, pos_ly, pos_dot;
    int merrs, maxly, zhits, vb_cnt, vb_ly, vb_dot;
    int wrap_irq, hb_irq, bad_irq, l143;
    logic [1:0] em;

    always #5 clk = ~clk;

    gb_ppu_timing dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_enable  (lcd_enable),
        .draw_done   (draw_done),
        .lyc         (lyc),
        .stat_irq_en (stat_irq_en),
        .ly          (ly),
        .dot         (dot),
        .ppu_mode    (ppu_mode),
        .lyc_eq      (lyc_eq),
        .line_start  (line_start),
        .stat_irq    (stat_irq),
        .vblank_irq  (vblank_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [1:0] exp_mode(input int d);
        if (d < 80) return 2'd2;
        else if (d < 369) return 2'd3;
        else return 2'd0;
    endfunction

    initial begin
        reset = 1'b1; lcd_enable = 1'b0; draw_done = 1'b0;
        lyc = 8'd5; stat_irq_en = 4'd0;
        tick(3);
        check("rst_ly",         32'(ly),         32'd0);
        check("rst_dot",        32'(dot),        32'd0);
        check("rst_mode",       32'(ppu_mode),   32'd0);
        check("rst_line_start", 32'(line_start), 32'd0);
        check("rst_stat_irq",   32'(stat_irq),   32'd0);
        check("rst_vblank_irq", 32'(vblank_irq), 32'd0);
        check("rst_lyc_eq_ne",  32'(lyc_eq),     32'd0);
        lyc = 8'd0;
        #1;
        check("rst_lyc_eq_eq",  32'(lyc_eq),     32'd1);

        // Enable edge and a full sweep of line 0 with draw_done tied low.
        reset = 1'b0; lcd_enable = 1'b1; lyc = 8'd200;
        tick(1);
        check("en_ly",         32'(ly),         32'd0);
        check("en_mode",       32'(ppu_mode),   32'd2);
        check("en_line_start", 32'(line_start), 32'd1);
        errs = 0;
        for (int c = 0; c < 456; c++) begin
            if (dot !== 9'(c) || ppu_mode !== exp_mode(c) || line_start !== (c == 0)
                || stat_irq !== 1'b0 || vblank_irq !== 1'b0) errs++;
            if (c == 79 || c == 80 || c == 368 || c == 369)
                check($sformatf("l0_mode_dot%0d", c), 32'(ppu_mode), 32'(exp_mode(c)));
            tick(1);
        end
        check("l0_sweep_errs",  32'(errs),       32'd0);
        check("l1_ly",          32'(ly),         32'd1);
        check("l1_dot",         32'(dot),        32'd0);
        check("l1_line_start",  32'(line_start), 32'd1);
        check("l1_mode",        32'(ppu_mode),   32'd2);

        // draw_done honoured in mode 3, ignored in mode 0, and coincident with forced end.
        tick(4 * 456 + 250);
        check("l5_ly",   32'(ly),       32'd5);
        check("l5_dot",  32'(dot),      32'd250);
        check("l5_mode", 32'(ppu_mode), 32'd3);
        draw_done = 1'b1; tick(1); draw_done = 1'b0;
        check("dd_dot",  32'(dot),      32'd251);
        check("dd_mode", 32'(ppu_mode), 32'd0);
        tick(49);
        check("dd2_pre_mode", 32'(ppu_mode), 32'd0);
        draw_done = 1'b1; tick(1); draw_done = 1'b0;
        check("dd2_dot",  32'(dot),      32'd301);
        check("dd2_mode", 32'(ppu_mode), 32'd0);
        tick(155 + 368);
        check("l6_dot",  32'(dot),      32'd368);
        check("l6_mode", 32'(ppu_mode), 32'd3);
        draw_done = 1'b1; tick(1); draw_done = 1'b0;
        check("fe_dot",  32'(dot),      32'd369);
        check("fe_mode", 32'(ppu_mode), 32'd0);

        // LYC interrupt: a single pulse entering line 10, lyc_eq for the whole line.
        lyc = 8'd10; stat_irq_en = 4'b1000;
        cnt = 0; errs = 0; hi = 0; pos_ly = -1; pos_dot = -1;
        for (int i = 0; i < 1911; i++) begin
            tick(1);
            if (stat_irq) begin cnt++; pos_ly = int'(ly); pos_dot = int'(dot); end
            if (lyc_eq !== (ly == 8'd10)) errs++;
            if (lyc_eq) hi++;
        end
        check("lyc_irq_cnt", 32'(cnt),     32'd1);
        check("lyc_irq_ly",  32'(pos_ly),  32'd10);
        check("lyc_irq_dot", 32'(pos_dot), 32'd0);
        check("lyc_eq_errs", 32'(errs),    32'd0);
        check("lyc_eq_hi",   32'(hi),      32'd456);
        check("lyc_end_ly",  32'(ly),      32'd11);

        // Disable mid-line in mode 3: immediate return to line 0, no pulses.
        tick(200);
        check("dis_pre_mode", 32'(ppu_mode), 32'd3);
        stat_irq_en = 4'b1101; lyc = 8'd0; lcd_enable = 1'b0;
        tick(1);
        check("dis_ly",         32'(ly),         32'd0);
        check("dis_dot",        32'(dot),        32'd0);
        check("dis_mode",       32'(ppu_mode),   32'd0);
        check("dis_line_start", 32'(line_start), 32'd0);
        check("dis_stat_irq",   32'(stat_irq),   32'd0);
        check("dis_vblank_irq", 32'(vblank_irq), 32'd0);
        check("dis_lyc_eq",     32'(lyc_eq),     32'd1);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (stat_irq || vblank_irq || line_start || dot != 9'd0 || ly != 8'd0 || ppu_mode != 2'd0)
                errs++;
        end
        check("dis_hold_errs", 32'(errs), 32'd0);

        stat_irq_en = 4'd0; lyc = 8'd10; lcd_enable = 1'b1;
        tick(1);
        check("ren_ly",         32'(ly),         32'd0);
        check("ren_dot",        32'(dot),        32'd0);
        check("ren_mode",       32'(ppu_mode),   32'd2);
        check("ren_line_start", 32'(line_start), 32'd1);
        tick(1);
        check("ren_dot1",        32'(dot),        32'd1);
        check("ren_line_start1", 32'(line_start), 32'd0);

        // One full frame with HBlank+OAM STAT sources; 70224 dots since the enable edge.
        tick(99);
        check("frm_pre_mode", 32'(ppu_mode), 32'd3);
        stat_irq_en = 4'b0101;
        merrs = 0; maxly = 0; zhits = 0; vb_cnt = 0; vb_ly = -1; vb_dot = -1;
        wrap_irq = 0; hb_irq = 0; bad_irq = 0; l143 = 0;
        for (int i = 0; i < 70124; i++) begin
            tick(1);
            if (ly >= 8'd144) em = 2'd1;
            else if (dot < 9'd80) em = 2'd2;
            else if (dot < 9'd369) em = 2'd3;
            else em = 2'd0;
            if (ppu_mode !== em) merrs++;
            if (int'(ly) > maxly) maxly = int'(ly);
            if (ly == 8'd0 && dot == 9'd0) zhits++;
            if (vblank_irq) begin vb_cnt++; vb_ly = int'(ly); vb_dot = int'(dot); end
            if (stat_irq) begin
                if (ly == 8'd0 && dot == 9'd0) wrap_irq++;
                else if (ly < 8'd144 && dot == 9'd369) hb_irq++;
                else bad_irq++;
                if (ly == 8'd143) l143++;
            end
        end
        check("frm_mode_errs", 32'(merrs),    32'd0);
        check("frm_max_ly",    32'(maxly),    32'd153);
        check("frm_zero_hits", 32'(zhits),    32'd1);
        check("frm_end_ly",    32'(ly),       32'd0);
        check("frm_end_dot",   32'(dot),      32'd0);
        check("frm_vb_cnt",    32'(vb_cnt),   32'd1);
        check("frm_vb_ly",     32'(vb_ly),    32'd144);
        check("frm_vb_dot",    32'(vb_dot),   32'd0);
        check("frm_hb_irq",    32'(hb_irq),   32'd144);
        check("frm_bad_irq",   32'(bad_irq),  32'd0);
        check("frm_l143_irq",  32'(l143),     32'd1);
        check("frm_wrap_irq",  32'(wrap_irq), 32'd1);

        // Reset mid-line overrides enable and draw_done.
        tick(456 + 150);
        check("rs_pre_ly", 32'(ly), 32'd1);
        reset = 1'b1; draw_done = 1'b1;
        tick(1);
        check("rs_ly",         32'(ly),         32'd0);
        check("rs_dot",        32'(dot),        32'd0);
        check("rs_mode",       32'(ppu_mode),   32'd0);
        check("rs_line_start", 32'(line_start), 32'd0);
        check("rs_stat_irq",   32'(stat_irq),   32'd0);
        check("rs_vblank_irq", 32'(vblank_irq), 32'd0);
        tick(1);
        check("rs_hold_dot", 32'(dot), 32'd0);
        stat_irq_en = 4'd0; draw_done = 1'b0; reset = 1'b0;
        tick(1);
        check("rs_rel_dot",        32'(dot),        32'd0);
        check("rs_rel_mode",       32'(ppu_mode),   32'd2);
        check("rs_rel_line_start", 32'(line_start), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
